mod_inv: RTL and testbench

- Sequential modular inverter: result = a^(-1) mod Q, computed by Fermat exponentiation a^(Q-2) mod Q.
- Uses right-to-left square-and-multiply, one iteration per cycle.
- Undoes a mod_mult scaling in the NTT datapath, e.g. to derive n^(-1) and inverse twiddles for the inverse-NTT normalization stage.
- Valid/ready handshake on both input and output; one operation in flight.

---
 rtl/mod_inv.sv | 91 +++++++++
 tb/tb_mod_inv.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod_inv.sv
// Sequential modular inverter: result = a^(Q-2) mod Q by right-to-left square-and-multiply.
// One squaring/multiply step per cycle, fixed latency, valid/ready on both sides.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for an operand, in_ready=1
//   RUN   | exponentiation in progress, one exponent bit per cycle
//   DONE  | result presented, held until out_ready
//   COOL  | one dead cycle after the output handshake before re-arming
module mod_inv #(
    parameter int          WIDTH = 32,
    parameter int unsigned Q     = 3329
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_err
);
    localparam int ITERS = $clog2(Q - 1);
    localparam int CW    = $clog2(ITERS + 1) + 1;
    localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] COOL = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] expo;
    logic [CW-1:0]    cnt;
    logic             zero_flag;

    logic [WIDTH-1:0] a_red;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] base_next;

    always_comb begin
        a_red     = WIDTH'({{WIDTH{1'b0}}, a} % QW);
        acc_next  = WIDTH'(({{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base}) % QW);
        base_next = WIDTH'(({{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base}) % QW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            base      <= '0;
            expo      <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base      <= a_red;
                        acc       <= WIDTH'(1);
                        expo      <= WIDTH'(Q - 2);
                        cnt       <= '0;
                        zero_flag <= (a_red == '0);
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // The last pass runs with expo already zero, so acc is untouched
                    // and only pads the latency out to ITERS+1 edges.
                    if (expo[0]) acc <= acc_next;
                    base <= base_next;
                    expo <= expo >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ITERS)) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= COOL;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = acc;
    assign zero_err  = zero_flag;
endmodule

// File: tb/tb_mod_inv.sv
// Directed bench for mod_inv: Q=3329 main instance plus a Q=17 instance.
module tb_mod_inv;
    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero_err;
    logic [31:0] a, result;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero_err;
    logic [31:0] s_a, s_result;

    int errors = 0;
    int checks = 0;

    mod_inv #(.WIDTH(32), .Q(3329)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero_err(zero_err)
    );

    mod_inv #(.WIDTH(32), .Q(17)) dut17 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .zero_err(s_zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Accept av, wait for out_valid (bounded), then complete the handshake with out_ready=1.
    task automatic do_op(input logic [31:0] av, output logic [31:0] r, output logic z,
                         output int lat, output logic busy_ok);
        in_valid = 1'b1;
        a        = av;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = '0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        z = zero_err;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic op_check(input string tag, input logic [31:0] av,
                            input logic [31:0] exp_r, input logic exp_z);
        logic [31:0] r;
        logic        z;
        int          lat;
        logic        busy_ok;
        do_op(av, r, z, lat, busy_ok);
        check({tag, "_lat"}, lat, 32'd13);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_res"}, r, exp_r);
        check({tag, "_zerr"}, {31'd0, z}, {31'd0, exp_z});
    endtask

    initial begin
        logic [31:0]     r, av;
        logic            z, busy_ok, stable;
        int              lat, ovc;
        longint unsigned m;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero_err", {31'd0, zero_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op_check("a17", 32'd17, 32'd1175, 1'b0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        op_check("a1", 32'd1, 32'd1, 1'b0);
        op_check("a2", 32'd2, 32'd1665, 1'b0);
        op_check("a3328", 32'd3328, 32'd3328, 1'b0);
        op_check("a3330", 32'd3330, 32'd1, 1'b0);
        op_check("a0", 32'd0, 32'd0, 1'b1);

        // back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1; a = 32'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", lat, 32'd13);
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && result === 32'd1175 && in_ready === 1'b0 && zero_err === 1'b0))
                stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_rel_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("bp_rearm_in_ready", {31'd0, in_ready}, 32'd1);
        op_check("bp_a2", 32'd2, 32'd1665, 1'b0);

        // reset mid-operation
        in_valid = 1'b1; a = 32'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_result", result, 32'd0);
        ovc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) ovc++;
        end
        check("mid_rst_no_output", ovc, 32'd0);
        op_check("mid_rst_a2", 32'd2, 32'd1665, 1'b0);

        // in_valid while busy is ignored
        in_valid = 1'b1; a = 32'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; a = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0; a = '0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_res", result, 32'd1175);
        ovc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) ovc++;
        end
        check("busy_single_output", ovc, 32'd0);

        // random sweep with an algebraic scoreboard; last entry is a multiple of Q
        for (int i = 0; i < 10; i++) begin
            av = (i == 9) ? 32'd23303 : $urandom();
            do_op(av, r, z, lat, busy_ok);
            check("sweep_lat", lat, 32'd13);
            if (av % 32'd3329 == 32'd0) begin
                check("sweep_zero_res", r, 32'd0);
                check("sweep_zero_err", {31'd0, z}, 32'd1);
            end else begin
                m = (longint'(av % 32'd3329) * longint'(r)) % 64'd3329;
                check("sweep_inverse", m[31:0], 32'd1);
                check("sweep_range", {31'd0, (r < 32'd3329)}, 32'd1);
                check("sweep_zerr", {31'd0, z}, 32'd0);
            end
        end

        // Q=17 instance
        s_in_valid = 1'b1; s_a = 32'd3;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("q17_lat", lat, 32'd5);
        check("q17_res", s_result, 32'd6);
        check("q17_zerr", {31'd0, s_zero_err}, 32'd0);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
